// File: rtl/wb_block_reader.sv
// Wishbone read sequencer: one start reads LEN consecutive byte words from START_ADR
// and delivers them through a small FIFO on a valid/ready stream, with a per-beat ack timeout.
module wb_block_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       start,
    input  logic [7:0] start_adr,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] m_wb_adr_o,
    output logic [7:0] m_wb_dat_o,
    output logic       m_wb_we_o,
    output logic       m_wb_cyc_o,
    output logic       m_wb_stb_o,
    input  logic [7:0] m_wb_dat_i,
    input  logic       m_wb_ack_i,
    output logic [2:0] dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]    state;
    logic [7:0]    adr;
    logic [8:0]    remaining;
    logic [7:0]    tmo;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;
    logic          has_free;

    // Stream handshake: a word transfers on every cycle where rd_valid && rd_ready;
    // rd_valid stays high and rd_data stable until that happens.
    assign push       = (state == S_REQ) && m_wb_ack_i;
    assign pop        = rd_valid && rd_ready;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    assign has_free   = (count != DEPTH_C) || pop;

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERR);
    assign m_wb_cyc_o = (state == S_REQ) || (state == S_WAIT);
    assign m_wb_stb_o = (state == S_REQ);
    assign m_wb_adr_o = adr;
    assign m_wb_dat_o = 8'h00;
    assign m_wb_we_o  = 1'b0;
    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;
    assign dbg_state  = state;

    // A start with a still-full FIFO (undrained words from an abort) parks in WAIT
    // so that stb is never raised without room for the ack.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state     <= S_IDLE;
            adr       <= 8'h00;
            remaining <= 9'd0;
            tmo       <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        adr       <= start_adr;
                        remaining <= {len == 8'd0, len};
                        tmo       <= 8'd0;
                        state     <= has_free ? S_REQ : S_WAIT;
                    end
                end
                S_REQ: begin
                    if (m_wb_ack_i) begin
                        adr       <= adr + 8'd1;
                        remaining <= remaining - 9'd1;
                        tmo       <= 8'd0;
                        if (remaining == 9'd1)
                            state <= S_DONE;
                        else if (count_next == DEPTH_C)
                            state <= S_WAIT;
                    end else if (tmo == TMO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (has_free) begin
                        tmo   <= 8'd0;
                        state <= S_REQ;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= m_wb_dat_i;
    end

endmodule

// File: tb/tb_wb_block_reader.sv
// Directed bench for wb_block_reader: a combinational ROM slave with an optional
// stalled address, a negedge monitor, and hand-computed expected streams.
module tb_wb_block_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_adr;
    logic [7:0] len;
    logic       busy, done, err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] m_wb_adr_o, m_wb_dat_o;
    logic       m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
    logic [7:0] m_wb_dat_i;
    logic       m_wb_ack_i;
    logic [2:0] dbg_state;

    logic       stall_en;
    logic [7:0] stall_adr;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int done_cnt, err_cnt, stall_cnt;
    int first_ack_cyc, last_ack_cyc, done_cyc;
    logic [7:0] ack_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_adr[$];

    wb_block_reader #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .start(start), .start_adr(start_adr), .len(len),
        .busy(busy), .done(done), .err(err), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o),
        .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
        .m_wb_dat_i(m_wb_dat_i), .m_wb_ack_i(m_wb_ack_i), .dbg_state(dbg_state)
    );

    // ---- clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rom(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'hA5;
    endfunction

    always_comb begin
        m_wb_ack_i = m_wb_stb_o && !(stall_en && (m_wb_adr_o == stall_adr));
        m_wb_dat_i = rom(m_wb_adr_o);
    end

    always @(negedge clk) begin
        if (m_wb_stb_o && m_wb_ack_i) begin
            if (ack_q.size() == 0) first_ack_cyc = cyc_n;
            ack_q.push_back(m_wb_adr_o);
            last_ack_cyc = cyc_n;
        end
        if (m_wb_stb_o && stall_en && (m_wb_adr_o == stall_adr)) stall_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc_n; end
        if (err) err_cnt++;
        if (rd_valid && rd_ready) rx_q.push_back(rd_data);
    end

    // ---- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] l);
        start = 1'b1; start_adr = a; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_sb();
        ack_q.delete(); rx_q.delete(); exp_q.delete(); exp_adr.delete();
        done_cnt = 0; err_cnt = 0; stall_cnt = 0;
    endtask

    // ---- scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_adr(input string tag);
        check({tag, "_acks"}, 32'(ack_q.size()), 32'(exp_adr.size()));
        for (int i = 0; i < exp_adr.size() && i < ack_q.size(); i++)
            check({tag, "_adr"}, 32'(ack_q[i]), 32'(exp_adr[i]));
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_words"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_data"}, 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    task automatic expect_run(input logic [7:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            exp_adr.push_back(a + 8'(i));
            exp_q.push_back(rom(a + 8'(i)));
        end
    endtask

    task automatic wait_end(input int bound);
        int base;
        int n;
        base = done_cnt + err_cnt;
        n = 0;
        while ((done_cnt + err_cnt) == base && n < bound) begin
            tick();
            n++;
        end
        check("end_reached", 32'((done_cnt + err_cnt) != base), 1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_adr = 8'h00; len = 8'h00;
        rd_ready = 1'b0; stall_en = 1'b0; stall_adr = 8'h00;
        clear_sb();
        ticks(3);
        check("rst_busy", 32'(busy), 0);
        check("rst_cyc", 32'(m_wb_cyc_o), 0);
        check("rst_stb", 32'(m_wb_stb_o), 0);
        check("rst_adr", 32'(m_wb_adr_o), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_we", 32'(m_wb_we_o), 0);
        check("rst_dat_o", 32'(m_wb_dat_o), 0);
        rst_n = 1'b1;
        tick();

        // 1: four back-to-back reads from 0x00
        clear_sb(); rd_ready = 1'b1;
        do_start(8'h00, 8'd4);
        check("t1_stb_latency", 32'(m_wb_stb_o), 1);
        check("t1_first_adr", 32'(m_wb_adr_o), 0);
        check("t1_busy", 32'(busy), 1);
        wait_end(20);
        ticks(2);
        expect_run(8'h00, 4);
        check_adr("t1");
        check_rx("t1");
        check("t1_consecutive", 32'(last_ack_cyc - first_ack_cyc), 3);
        check("t1_done_timing", 32'(done_cyc - last_ack_cyc), 1);
        check("t1_done_cnt", 32'(done_cnt), 1);
        check("t1_err_cnt", 32'(err_cnt), 0);
        check("t1_idle", 32'(busy), 0);

        // 2: address wraps FE, FF, 00
        clear_sb();
        do_start(8'hFE, 8'd3);
        wait_end(20);
        ticks(2);
        expect_run(8'hFE, 3);
        check_adr("t2");
        check_rx("t2");
        check("t2_done_cnt", 32'(done_cnt), 1);

        // 3: len=0 reads 256 words
        clear_sb();
        do_start(8'h10, 8'd0);
        wait_end(400);
        ticks(2);
        expect_run(8'h10, 256);
        check_adr("t3");
        check_rx("t3");
        check("t3_done_cnt", 32'(done_cnt), 1);
        check("t3_err_cnt", 32'(err_cnt), 0);

        // 4: backpressure fills the FIFO, then drains
        clear_sb(); rd_ready = 1'b0;
        do_start(8'h20, 8'd8);
        ticks(20);
        check("t4_acks_full", 32'(ack_q.size()), 4);
        check("t4_wait_cyc", 32'(m_wb_cyc_o), 1);
        check("t4_wait_stb", 32'(m_wb_stb_o), 0);
        check("t4_wait_state", 32'(dbg_state), 2);
        check("t4_rd_valid", 32'(rd_valid), 1);
        check("t4_head", 32'(rd_data), 32'(rom(8'h20)));
        rd_ready = 1'b1;
        wait_end(60);
        ticks(6);
        expect_run(8'h20, 8);
        check_adr("t4");
        check_rx("t4");
        check("t4_done_cnt", 32'(done_cnt), 1);

        // 5: third beat never acked -> timeout, earlier words still drainable
        clear_sb(); rd_ready = 1'b0;
        stall_en = 1'b1; stall_adr = 8'h42;
        do_start(8'h40, 8'd5);
        wait_end(60);
        check("t5_err_cnt", 32'(err_cnt), 1);
        check("t5_done_cnt", 32'(done_cnt), 0);
        check("t5_stb_cycles", 32'(stall_cnt), 15);
        check("t5_cyc_after", 32'(m_wb_cyc_o), 0);
        check("t5_busy_after", 32'(busy), 0);
        check("t5_rd_valid", 32'(rd_valid), 1);
        stall_en = 1'b0; rd_ready = 1'b1;
        ticks(4);
        expect_run(8'h40, 2);
        check_adr("t5");
        check_rx("t5");
        check("t5_empty", 32'(rd_valid), 0);

        // 6: reset mid-burst aborts silently; start while busy is ignored
        clear_sb();
        do_start(8'h80, 8'd20);
        ticks(5);
        rst_n = 1'b0;
        tick();
        check("t6_cyc", 32'(m_wb_cyc_o), 0);
        check("t6_stb", 32'(m_wb_stb_o), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_rd_valid", 32'(rd_valid), 0);
        rst_n = 1'b1;
        ticks(3);
        check("t6_no_done", 32'(done_cnt), 0);
        check("t6_no_err", 32'(err_cnt), 0);
        clear_sb();
        do_start(8'h90, 8'd3);
        do_start(8'hA0, 8'd9);
        wait_end(20);
        ticks(5);
        expect_run(8'h90, 3);
        check_adr("t6");
        check_rx("t6");
        check("t6_done_cnt", 32'(done_cnt), 1);
        check("t6_idle", 32'(dbg_state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
